// File: rtl/xc_malu_muldiv_p_pkg.sv
// Shared constants for the xc_malu multiply/divide datapath: FSM encodings,
// uop one-hot codes, per-iteration step selectors and W-parametric special values.
package xc_malu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] UOP_MUL = 3'b001;
  localparam logic [2:0] UOP_DIV = 3'b010;
  localparam logic [2:0] UOP_REM = 3'b100;

  localparam logic [1:0] STEP_MUL   = 2'd0;
  localparam logic [1:0] STEP_CLMUL = 2'd1;
  localparam logic [1:0] STEP_DIV   = 2'd2;

  // Helpers return MAX_W-bit values; callers keep the low W bits.
  localparam int MAX_W = 256;

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] min_signed(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/xc_malu_muldiv_p_if.sv
// Decode-side valid/ready/flush bundle of the multiply/divide unit.
interface xc_malu_muldiv_p_if #(
  parameter int W = 32
);
  logic           flush;
  logic           valid;
  logic [W-1:0]   rs1;
  logic [W-1:0]   rs2;
  logic           uop_mul;
  logic           uop_div;
  logic           uop_rem;
  logic           mod_lh_sign;
  logic           mod_rh_sign;
  logic           mod_carryless;
  logic [2*W-1:0] result;
  logic           ready;

  modport master (
    output flush, valid, rs1, rs2, uop_mul, uop_div, uop_rem,
           mod_lh_sign, mod_rh_sign, mod_carryless,
    input  result, ready
  );

  modport slave (
    input  flush, valid, rs1, rs2, uop_mul, uop_div, uop_rem,
           mod_lh_sign, mod_rh_sign, mod_carryless,
    output result, ready
  );
endinterface

// File: rtl/xc_malu_muldiv_p_step.sv
// One combinational iteration of the datapath on the {hi, lo} accumulator pair:
// add-shift (mul), xor-shift (clmul) or restoring compare-subtract (div/rem).
module xc_malu_step
  import xc_malu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   op_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);
  logic [W:0]   sum;
  logic [W-1:0] xorAcc;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // The partial remainder stays below the divisor, so diff[W] is a pure borrow flag.
  always_comb begin
    sum     = {1'b0, hi_i} + ({1'b0, b_i} & {(W + 1){lo_i[0]}});
    xorAcc  = hi_i ^ (b_i & {W{lo_i[0]}});
    shifted = {hi_i, lo_i[W-1]};
    diff    = shifted - {1'b0, b_i};
    hi_o    = hi_i;
    lo_o    = lo_i;
    case (op_i)
      STEP_MUL: begin
        hi_o = sum[W:1];
        lo_o = {sum[0], lo_i[W-1:1]};
      end
      STEP_CLMUL: begin
        hi_o = {1'b0, xorAcc[W-1:1]};
        lo_o = {xorAcc[0], lo_i[W-1:1]};
      end
      STEP_DIV: begin
        hi_o = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        lo_o = {lo_i[W-2:0], ~diff[W]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/xc_malu_muldiv_p.sv
// Sequential multiply/divide unit: FSM, operand sign handling and result
// formatting around a BPC-deep chain of xc_malu_step iterations.
module xc_malu_muldiv_p
  import xc_malu_pkg::*;
#(
  parameter int W   = 32,
  parameter int BPC = 1
) (
  input  logic              clock,
  input  logic              resetn,
  xc_malu_muldiv_p_if.slave bus
);
  localparam int N  = W / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]    LAST      = CW'(N);
  localparam logic [MAX_W-1:0] ONES_FULL = all_ones(W);
  localparam logic [MAX_W-1:0] MIN_FULL  = min_signed(W);
  localparam logic [W-1:0]     ONES      = ONES_FULL[W-1:0];
  localparam logic [W-1:0]     MIN_S     = MIN_FULL[W-1:0];

  if ((W < 8) || (W % 2 != 0) || (W > MAX_W) ||
      !(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8) || (W % BPC != 0)) begin : g_bad_params
    $error("xc_malu_muldiv_p: illegal W/BPC combination");
  end

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic           legal_q, legal_d, isMul_q, isMul_d, isRem_q, isRem_d;
  logic           negRes_q, negRes_d, negRem_q, negRem_d;
  logic           divZero_q, divZero_d, ovf_q, ovf_d;
  logic [2*W-1:0] result_q, result_d, fmt;

  logic [2:0]     uopVec;
  logic           uopLegal, clmul, isDivRem, lhNeg, rhNeg;
  logic [W-1:0]   aMag, bMag;

  always_comb begin
    uopVec   = {bus.uop_rem, bus.uop_div, bus.uop_mul};
    uopLegal = (uopVec == UOP_MUL) || (uopVec == UOP_DIV) || (uopVec == UOP_REM);
    clmul    = (uopVec == UOP_MUL) && bus.mod_carryless;
    isDivRem = (uopVec == UOP_DIV) || (uopVec == UOP_REM);
    lhNeg    = bus.mod_lh_sign && !clmul && bus.rs1[W-1];
    rhNeg    = bus.mod_rh_sign && !clmul && bus.rs2[W-1];
    aMag     = lhNeg ? -bus.rs1 : bus.rs1;
    bMag     = rhNeg ? -bus.rs2 : bus.rs2;
  end

  logic [W-1:0] hiChain [BPC+1];
  logic [W-1:0] loChain [BPC+1];
  assign hiChain[0] = hi_q;
  assign loChain[0] = lo_q;

  for (genvar g = 0; g < BPC; g++) begin : g_step
    xc_malu_step #(.W(W)) u_step (
      .op_i (op_q),
      .hi_i (hiChain[g]),
      .lo_i (loChain[g]),
      .b_i  (b_q),
      .hi_o (hiChain[g+1]),
      .lo_o (loChain[g+1])
    );
  end

  // After N steps hi holds the remainder / upper product and lo the quotient / lower product.
  logic [2*W-1:0] prod, mulRes;
  logic [W-1:0]   quot, rem;
  always_comb begin
    prod   = {hi_q, lo_q};
    mulRes = negRes_q ? -prod : prod;
    quot   = negRes_q ? -lo_q : lo_q;
    rem    = negRem_q ? -hi_q : hi_q;
    if (divZero_q) quot = ONES;
    if (ovf_q) begin
      quot = MIN_S;
      rem  = '0;
    end
    if (!legal_q)     fmt = '0;
    else if (isMul_q) fmt = mulRes;
    else              fmt = {{W{1'b0}}, isRem_q ? rem : quot};
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    op_d      = op_q;
    legal_d   = legal_q;
    isMul_d   = isMul_q;
    isRem_d   = isRem_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid && !bus.flush) begin
          state_d   = ST_RUN;
          count_d   = '0;
          hi_d      = '0;
          lo_d      = aMag;
          b_d       = bMag;
          op_d      = clmul ? STEP_CLMUL : (isDivRem ? STEP_DIV : STEP_MUL);
          legal_d   = uopLegal;
          isMul_d   = (uopVec == UOP_MUL);
          isRem_d   = (uopVec == UOP_REM);
          negRes_d  = lhNeg ^ rhNeg;
          negRem_d  = lhNeg;
          divZero_d = (bus.rs2 == '0);
          ovf_d     = isDivRem && bus.mod_lh_sign && bus.mod_rh_sign &&
                      (bus.rs1 == MIN_S) && (bus.rs2 == ONES);
        end
      end
      ST_RUN: begin
        if (bus.flush || !bus.valid) begin
          state_d = ST_IDLE;
        end else if (count_q == LAST) begin
          state_d  = ST_DONE;
          result_d = fmt;
        end else begin
          hi_d    = hiChain[BPC];
          lo_d    = loChain[BPC];
          count_d = count_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      op_q      <= STEP_MUL;
      legal_q   <= 1'b0;
      isMul_q   <= 1'b0;
      isRem_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      op_q      <= op_d;
      legal_q   <= legal_d;
      isMul_q   <= isMul_d;
      isRem_q   <= isRem_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready  = (state_q == ST_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_xc_malu_muldiv_p.sv
// Directed bench: the same stimulus drives a BPC=1 and a BPC=4 build side by side,
// checking results, latency and the flush / valid-drop / reset abort paths.
module tb_xc_malu_muldiv_p;
  import xc_malu_pkg::*;

  localparam int W = 32;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  xc_malu_muldiv_p_if #(.W(W)) bus1 ();
  xc_malu_muldiv_p_if #(.W(W)) bus4 ();

  xc_malu_muldiv_p #(.W(W), .BPC(1)) dut1 (.clock(clock), .resetn(resetn), .bus(bus1));
  xc_malu_muldiv_p #(.W(W), .BPC(4)) dut4 (.clock(clock), .resetn(resetn), .bus(bus4));

  int compared   = 0;
  int mismatched = 0;
  int lat1;
  int lat4;
  int readySeen;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
      end
  endtask

  task automatic idleInputs();
    bus1.flush = 1'b0; bus1.valid = 1'b0; bus1.rs1 = '0; bus1.rs2 = '0;
    bus1.uop_mul = 1'b0; bus1.uop_div = 1'b0; bus1.uop_rem = 1'b0;
    bus1.mod_lh_sign = 1'b0; bus1.mod_rh_sign = 1'b0; bus1.mod_carryless = 1'b0;
    bus4.flush = 1'b0; bus4.valid = 1'b0; bus4.rs1 = '0; bus4.rs2 = '0;
    bus4.uop_mul = 1'b0; bus4.uop_div = 1'b0; bus4.uop_rem = 1'b0;
    bus4.mod_lh_sign = 1'b0; bus4.mod_rh_sign = 1'b0; bus4.mod_carryless = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] uop, input logic lh, input logic rh,
                               input logic cl, input logic [31:0] a, input logic [31:0] b);
    bus1.flush = 1'b0; bus1.valid = 1'b1; bus1.rs1 = a; bus1.rs2 = b;
    bus1.uop_mul = uop[0]; bus1.uop_div = uop[1]; bus1.uop_rem = uop[2];
    bus1.mod_lh_sign = lh; bus1.mod_rh_sign = rh; bus1.mod_carryless = cl;
    bus4.flush = 1'b0; bus4.valid = 1'b1; bus4.rs1 = a; bus4.rs2 = b;
    bus4.uop_mul = uop[0]; bus4.uop_div = uop[1]; bus4.uop_rem = uop[2];
    bus4.mod_lh_sign = lh; bus4.mod_rh_sign = rh; bus4.mod_carryless = cl;
  endtask

  task automatic setFlushValid(input logic f, input logic v);
    bus1.flush = f; bus1.valid = v;
    bus4.flush = f; bus4.valid = v;
  endtask

  // Latency counts rising edges after the one that samples valid.
  task automatic waitReady();
    int cycles;
    cycles = 0;
    lat1 = -1;
    lat4 = -1;
    while ((lat1 < 0 || lat4 < 0) && cycles < 100) begin
      @(posedge clock);
      @(negedge clock);
      cycles++;
      if (bus1.ready && lat1 < 0) lat1 = cycles - 1;
      if (bus4.ready && lat4 < 0) lat4 = cycles - 1;
    end
  endtask

  task automatic retire();
    setFlushValid(1'b1, 1'b0);
    @(posedge clock);
    @(negedge clock);
    idleInputs();
  endtask

  task automatic runCheck(input string tag, input logic [2:0] uop, input logic lh, input logic rh,
                          input logic cl, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expected);
    applyStimulus(uop, lh, rh, cl, a, b);
    waitReady();
    checkOutput({tag, "/bpc1"}, bus1.result, expected);
    checkOutput({tag, "/bpc4"}, bus4.result, expected);
    checkOutput({tag, "/lat1"}, 64'(lat1), 64'd33);
    checkOutput({tag, "/lat4"}, 64'(lat4), 64'd9);
    retire();
  endtask

  task automatic watchReady(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      readySeen += int'(bus1.ready) + int'(bus4.ready);
    end
  endtask

  initial begin
    resetn = 1'b0;
    idleInputs();
    repeat (3) @(negedge clock);
    checkOutput("reset/ready1", 64'(bus1.ready), 64'd0);
    checkOutput("reset/ready4", 64'(bus4.ready), 64'd0);
    checkOutput("reset/result1", bus1.result, 64'd0);
    checkOutput("reset/result4", bus4.result, 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    runCheck("mul_ss", UOP_MUL, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE);
    runCheck("mul_uu", UOP_MUL, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE);
    runCheck("mul_su", UOP_MUL, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h80000000, 64'hFFFFFFFF_80000000);
    runCheck("mul_us", UOP_MUL, 1'b0, 1'b1, 1'b0, 32'h00000003, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFA);
    runCheck("mul_uu_max", UOP_MUL, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    runCheck("clmul", UOP_MUL, 1'b0, 1'b0, 1'b1, 32'h80000001, 32'h80000001, 64'h40000000_00000001);
    runCheck("clmul_sgn", UOP_MUL, 1'b1, 1'b1, 1'b1, 32'h80000001, 32'h80000001, 64'h40000000_00000001);

    // Flush after five RUN edges; flush and valid stay high so a missed abort would complete.
    applyStimulus(UOP_MUL, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000002);
    repeat (6) begin
      @(posedge clock);
      @(negedge clock);
    end
    setFlushValid(1'b1, 1'b1);
    readySeen = 0;
    watchReady(40);
    checkOutput("flush_run/ready", 64'(readySeen), 64'd0);
    checkOutput("flush_run/hold1", bus1.result, 64'h40000000_00000001);
    checkOutput("flush_run/hold4", bus4.result, 64'h40000000_00000001);
    idleInputs();
    @(negedge clock);

    runCheck("div_ovf", UOP_DIV, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    runCheck("rem_ovf", UOP_REM, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_00000000);
    runCheck("divu_by0", UOP_DIV, 1'b0, 1'b0, 1'b0, 32'h00000007, 32'h00000000, 64'h00000000_FFFFFFFF);
    runCheck("rem_by0", UOP_REM, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000000, 64'h00000000_FFFFFFF9);
    runCheck("div_neg", UOP_DIV, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000000_FFFFFFFD);
    runCheck("rem_neg", UOP_REM, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000000_FFFFFFFF);
    runCheck("divu", UOP_DIV, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 64'd14);
    runCheck("remu", UOP_REM, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 64'd2);
    runCheck("illegal_none", 3'b000, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h00000003, 64'd0);
    runCheck("illegal_two", 3'b011, 1'b0, 1'b0, 1'b0, 32'h00000064, 32'h00000007, 64'd0);

    // Dropping valid during RUN must abandon the operation.
    applyStimulus(UOP_MUL, 1'b0, 1'b0, 1'b0, 32'h00000005, 32'h00000006);
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
    end
    setFlushValid(1'b0, 1'b0);
    readySeen = 0;
    watchReady(40);
    checkOutput("valid_drop/ready", 64'(readySeen), 64'd0);
    idleInputs();
    runCheck("after_drop", UOP_MUL, 1'b0, 1'b0, 1'b0, 32'h00000005, 32'h00000006, 64'd30);

    // Asynchronous reset in the middle of RUN clears outputs without waiting for an edge.
    applyStimulus(UOP_DIV, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002);
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    resetn = 1'b0;
    #1;
    checkOutput("midreset/ready1", 64'(bus1.ready), 64'd0);
    checkOutput("midreset/ready4", 64'(bus4.ready), 64'd0);
    checkOutput("midreset/result1", bus1.result, 64'd0);
    checkOutput("midreset/result4", bus4.result, 64'd0);
    idleInputs();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    runCheck("after_reset", UOP_REM, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000000_FFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
